test_result_reporter: RTL
=========================

// Module: test_result_reporter
// PURPOSE
//  On-chip counterpart of the sim pass/fail checker. Watches core regs x26 (test end flag), x27 (pass flag) and
//  x3 (failing test number). Once per reset, serialises an ASCII verdict on a dedicated 8N1 UART TX line.
//  Lets FPGA boards running riscv-tests report results without a simulator. Instanced in yadan_riscv_sopc beside uart.
// PARAMETERS
//  CLK_FREQ       50_000_000  core clock in Hz
//  BAUD           115200      line rate; CLKS_PER_BIT = CLK_FREQ/BAUD, floor (434 at defaults), must be >= 2
//  SETTLE_CYCLES  5           clocks between end-flag detect and sampling x27/x3 (lets the core retire writes)
// PORTS
//  clk            in   1   core clock
//  rst            in   1   synchronous reset, active-high
//  test_end_i     in   32  x26 value; end condition is test_end_i == 32'h1
//  test_pass_i    in   32  x27 value; pass when == 32'h1, any other value is fail
//  test_num_i     in   32  x3 value; failing test number
//  uart_tx_o      out  1   serial output, idle high
//  busy_o         out  1   high from end detect until last stop bit completes
//  report_done_o  out  1   sticky high after the report is fully sent, until rst
//  report_pass_o  out  1   latched verdict, valid while report_done_o is high
// BEHAVIOUR
//  Reset values: uart_tx_o=1, busy_o=0, report_done_o=0, report_pass_o=0. FSM enters IDLE.
//  FSM states: IDLE -> SETTLE -> CONVERT -> SEND -> DONE. DONE is terminal until rst. Exactly one report per reset.
//  IDLE: on the first clk with test_end_i==1, go to SETTLE and set busy_o on the next cycle.
//    The end flag is edge-free; it is latched internally, so later deassertion of test_end_i is ignored.
//  SETTLE: count SETTLE_CYCLES clocks, then sample test_pass_i and test_num_i into internal regs.
//  CONVERT: sat = min(test_num,99). tens/ones come from repeated subtraction of 10, one step per clk, <=10 clks.
//    On pass, CONVERT takes 1 clk and does no conversion.
//  Message on pass: "PASS\r\n" = 50 41 53 53 0D 0A (6 bytes).
//  Message on fail: "FAIL " + tens + ones + "\r\n", digits as 0x30+d (9 bytes).
//    Example: x3=7 gives 46 41 49 4C 20 30 37 0D 0A. x3=250 is sent as "99".
//  SEND: bytes go out in order with no idle gap between frames.
//    Each frame: start bit 0, then 8 data bits LSB first, then 1 stop bit 1. Every bit lasts exactly CLKS_PER_BIT clks.
//    The start bit of byte 0 begins the clk after CONVERT exits.
//  DONE: entered on the clk after the last stop bit ends. busy_o=0, report_done_o=1, report_pass_o=latched verdict.
//  Latency at defaults, pass case: detect->DONE = 1+5+1+6*10*434 clks.
//  rst mid-operation, including mid-bit: next clk uart_tx_o=1 and all outputs at reset values. No partial-frame recovery.
//  test_end_i high while already in reset: detection starts on the first clk after rst drops.
//  Widths: byte index 4 bits; bit counter 4 bits; baud counter $clog2(CLKS_PER_BIT) bits, wraps to 0 at CLKS_PER_BIT-1.
// STRUCTURE
//  Shared defines header (`include alongside yadan_defs.v) holds:
//    ASCII constants ASCII_P/A/S/F/I/L/SP/CR/LF/ZERO.
//    Verdict values TEST_END_VAL=32'h1 and TEST_PASS_VAL=32'h1, shared with the testbench checker.
//  FSM state encodings and the message-byte mux stay local to the module.
//  One sub-module: uart_tx_byte (CLKS_PER_BIT param; clk, rst, data_i[7:0], valid_i, ready_o, tx_o).
//    ready_o is high in idle and on the final stop-bit clk, which allows back-to-back frames.
//    The reporter holds valid_i and advances the byte index on valid_i&&ready_o.
// TESTING  (bench: CLK_FREQ=1000, BAUD=100 -> 10 clks/bit; SETTLE_CYCLES=5; UART monitor samples mid-bit)
//  1 x26=1, x27=1 -> monitor decodes 50 41 53 53 0D 0A; report_done_o=1 and report_pass_o=1 exactly 7+600 clks after detect.
//  2 x26=1, x27=0, x3=7 -> decodes 46 41 49 4C 20 30 37 0D 0A; report_pass_o=0; busy_o high for whole report.
//  3 x3=250 fail -> digits "99". Also x3=0 -> "00". Check CONVERT length <=10 clks for each value.
//  4 x26 pulsed high for 1 clk only -> full report still sent. x26 re-pulsed after DONE -> no second report, tx stays 1.
//  5 rst asserted mid-way through byte 2 data bits -> uart_tx_o=1 and busy_o=0 next clk.
//    Then assert x26=1 with x27=1 -> fresh complete "PASS\r\n".
//  6 x27 changes 0->1 at clk 3 of SETTLE -> verdict is PASS (sampled at end of SETTLE).
//    Inter-frame check: stop bit of byte n is followed directly by start bit of byte n+1.

Source files
------------

// File: rtl/test_result_reporter_pkg.sv
// Shared constants for the on-chip test verdict reporter: ASCII message bytes and the
// register values that mean "test ended" and "test passed".
package test_result_reporter_pkg;

  localparam logic [7:0] ASCII_P    = 8'h50;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_S    = 8'h53;
  localparam logic [7:0] ASCII_F    = 8'h46;
  localparam logic [7:0] ASCII_I    = 8'h49;
  localparam logic [7:0] ASCII_L    = 8'h4C;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  localparam logic [31:0] TEST_END_VAL  = 32'h1;
  localparam logic [31:0] TEST_PASS_VAL = 32'h1;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/test_result_reporter_uart_tx.sv
// 8N1 transmitter for one byte per handshake; ready_o rises on the final stop-bit clock
// so a held valid_i chains frames with no idle gap.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic            active_q;
  logic [3:0]      bit_q;
  logic [CntW-1:0] baud_q;
  logic [8:0]      shift_q;
  logic            tx_q;
  logic            bit_end;

  assign bit_end = (baud_q == CntMax);
  assign ready_o = !active_q || ((bit_q == 4'd9) && bit_end);
  assign tx_o    = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      baud_q   <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else if (valid_i && ready_o) begin
      // Start bit goes out now; the stop bit sits at the top of the shifter.
      active_q <= 1'b1;
      bit_q    <= 4'd0;
      baud_q   <= '0;
      shift_q  <= {1'b1, data_i};
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        baud_q <= '0;
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
          bit_q    <= 4'd0;
          tx_q     <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        baud_q <= baud_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/test_result_reporter.sv
// Watches the test end/pass/number registers and sends a one-shot ASCII verdict
// ("PASS\r\n" or "FAIL nn\r\n") on a dedicated UART line once per reset.
module test_result_reporter
  import test_result_reporter_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned SETTLE_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] test_end_i,
  input  logic [31:0] test_pass_i,
  input  logic [31:0] test_num_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        report_done_o,
  output logic        report_pass_o
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSettle, StConvert, StSend, StDone} state_e;

  state_e             state_q;
  logic [SettleW-1:0] settle_q;
  logic [3:0]         idx_q;
  logic               pass_q;
  logic [6:0]         rem_q;
  logic [3:0]         tens_q;
  logic               busy_q, done_q, verdict_q;
  logic [3:0]         msg_len;
  logic [7:0]         msg_byte;
  logic [6:0]         sat_num;
  logic               tx_valid, tx_ready;

  assign sat_num  = (test_num_i > 32'd99) ? 7'd99 : test_num_i[6:0];
  assign msg_len  = pass_q ? 4'd6 : 4'd9;
  assign tx_valid = (state_q == StSend) && (idx_q != msg_len);

  always_comb begin
    msg_byte = ASCII_LF;
    if (pass_q) begin
      case (idx_q)
        4'd0:    msg_byte = ASCII_P;
        4'd1:    msg_byte = ASCII_A;
        4'd2:    msg_byte = ASCII_S;
        4'd3:    msg_byte = ASCII_S;
        4'd4:    msg_byte = ASCII_CR;
        default: msg_byte = ASCII_LF;
      endcase
    end else begin
      case (idx_q)
        4'd0:    msg_byte = ASCII_F;
        4'd1:    msg_byte = ASCII_A;
        4'd2:    msg_byte = ASCII_I;
        4'd3:    msg_byte = ASCII_L;
        4'd4:    msg_byte = ASCII_SP;
        4'd5:    msg_byte = digit_to_ascii(tens_q);
        4'd6:    msg_byte = digit_to_ascii(rem_q[3:0]);
        4'd7:    msg_byte = ASCII_CR;
        default: msg_byte = ASCII_LF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      idx_q     <= 4'd0;
      pass_q    <= 1'b0;
      rem_q     <= 7'd0;
      tens_q    <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      verdict_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (test_end_i == TEST_END_VAL) begin
            state_q  <= StSettle;
            settle_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        StSettle: begin
          if (settle_q == SettleLast) begin
            pass_q  <= (test_pass_i == TEST_PASS_VAL);
            rem_q   <= sat_num;
            tens_q  <= 4'd0;
            state_q <= StConvert;
          end else begin
            settle_q <= settle_q + SettleW'(1);
          end
        end
        StConvert: begin
          // One subtract-by-ten per clock; rem_q is left holding the ones digit.
          if (pass_q || (rem_q < 7'd10)) begin
            idx_q   <= 4'd0;
            state_q <= StSend;
          end else begin
            rem_q  <= rem_q - 7'd10;
            tens_q <= tens_q + 4'd1;
          end
        end
        StSend: begin
          // After the last byte is accepted, the next ready marks the end of its stop bit.
          if (tx_ready) begin
            if (idx_q == msg_len) begin
              state_q   <= StDone;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              verdict_q <= pass_q;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        StDone:  state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(ClksPerBit)
  ) u_uart_tx (
    .clk    (clk),
    .rst    (rst),
    .data_i (msg_byte),
    .valid_i(tx_valid),
    .ready_o(tx_ready),
    .tx_o   (uart_tx_o)
  );

  assign busy_o        = busy_q;
  assign report_done_o = done_q;
  assign report_pass_o = verdict_q;

endmodule
